// File: rtl/pc_sequencer_if.sv
// Bus between decode/branch logic and the PC sequencer.
// BRANCH_PERF_CNT_EN adds the branch counter outputs.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             is_branch;
  logic             branch_taken;
  logic             is_jal;
  logic             is_jalr;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             redirect;
  logic             trap;
  logic [WIDTH-1:0] bad_target;
`ifdef BRANCH_PERF_CNT_EN
  logic [WIDTH-1:0] br_count;
  logic [WIDTH-1:0] br_taken_count;

  modport master (
    output stall, is_branch, branch_taken,
    output is_jal, is_jalr, imm, rs1_val,
    input  pc, pc_plus4, redirect, trap,
    input  bad_target,
    input  br_count, br_taken_count
  );

  modport slave (
    input  stall, is_branch, branch_taken,
    input  is_jal, is_jalr, imm, rs1_val,
    output pc, pc_plus4, redirect, trap,
    output bad_target,
    output br_count, br_taken_count
  );
`else
  modport master (
    output stall, is_branch, branch_taken,
    output is_jal, is_jalr, imm, rs1_val,
    input  pc, pc_plus4, redirect, trap,
    input  bad_target
  );

  modport slave (
    input  stall, is_branch, branch_taken,
    input  is_jal, is_jalr, imm, rs1_val,
    output pc, pc_plus4, redirect, trap,
    output bad_target
  );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// PC register, next-PC select and misaligned-target trap sequencing.
// Optional BRANCH_PERF_CNT_EN adds saturating branch counters.
module pc_sequencer #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(32'h0000_0100)
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.slave  bus
);

  typedef enum logic {
    RUN,
    TRAP
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] bad_q;
  logic             redirect_q;
  logic             trap_q;

  logic [WIDTH-1:0] plus4;
  logic [WIDTH-1:0] rel_tgt;
  logic [WIDTH-1:0] jalr_sum;
  logic [WIDTH-1:0] tgt;
  logic             take;
  logic             misal;

  always_comb begin
    plus4    = pc_q + WIDTH'(4);
    rel_tgt  = pc_q + bus.imm;
    jalr_sum = bus.rs1_val + bus.imm;
    tgt      = rel_tgt;
    take     = 1'b1;
    priority case (1'b1)
      bus.is_jalr:
        tgt = jalr_sum & ~WIDTH'(1);
      bus.is_jal:
        tgt = rel_tgt;
      bus.is_branch & bus.branch_taken:
        tgt = rel_tgt;
      default:
        take = 1'b0;
    endcase
    // bit0 survives only on pc-relative targets
    misal = take & (tgt[1] | tgt[0]);
    pc_d  = take ? tgt : plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      bad_q      <= '0;
      redirect_q <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.stall) begin
            redirect_q <= 1'b0;
          end else if (misal) begin
            pc_q       <= TRAP_VEC;
            bad_q      <= tgt;
            state_q    <= TRAP;
            redirect_q <= 1'b1;
            trap_q     <= 1'b1;
          end else begin
            pc_q       <= pc_d;
            redirect_q <= take;
          end
        end
        TRAP: begin
          // handler at TRAP_VEC is entered; advance past it
          pc_q       <= plus4;
          state_q    <= RUN;
          redirect_q <= 1'b0;
          trap_q     <= 1'b0;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = plus4;
  assign bus.redirect   = redirect_q;
  assign bus.trap       = trap_q;
  assign bus.bad_target = bad_q;

`ifdef BRANCH_PERF_CNT_EN
  logic [WIDTH-1:0] br_cnt_q;
  logic [WIDTH-1:0] tk_cnt_q;
  logic             cnt_en;

  assign cnt_en = (state_q == RUN) & ~bus.stall
                & bus.is_branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else if (cnt_en) begin
      if (br_cnt_q != '1)
        br_cnt_q <= br_cnt_q + WIDTH'(1);
      if (bus.branch_taken && tk_cnt_q != '1)
        tk_cnt_q <= tk_cnt_q + WIDTH'(1);
    end
  end

  assign bus.br_count       = br_cnt_q;
  assign bus.br_taken_count = tk_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push
// expected post-edge state, a monitor pops and compares.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(
    .WIDTH   (32),
    .RESET_PC(32'h0000_0000),
    .TRAP_VEC(32'h0000_0100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        rd;
    logic        tr;
    logic [31:0] bad;
  } exp_t;

  exp_t q[$];
  int   n_total;
  int   n_pass;
  event sample_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string nm, input logic [31:0] epc,
                      input logic erd, input logic etr,
                      input logic [31:0] ebad);
    exp_t e;
    e.name = nm;
    e.pc   = epc;
    e.rd   = erd;
    e.tr   = etr;
    e.bad  = ebad;
    q.push_back(e);
  endtask

  task automatic drive(input logic st, input logic br,
                       input logic tk, input logic jal,
                       input logic jalr, input logic [31:0] im,
                       input logic [31:0] rs);
    bus.stall        = st;
    bus.is_branch    = br;
    bus.branch_taken = tk;
    bus.is_jal       = jal;
    bus.is_jalr      = jalr;
    bus.imm          = im;
    bus.rs1_val      = rs;
  endtask

  task automatic cyc(input string nm, input logic st,
                     input logic br, input logic tk,
                     input logic jal, input logic jalr,
                     input logic [31:0] im, input logic [31:0] rs,
                     input logic [31:0] epc, input logic erd,
                     input logic etr, input logic [31:0] ebad);
    drive(st, br, tk, jal, jalr, im, rs);
    @(posedge clk);
    #1;
    push(nm, epc, erd, etr, ebad);
  endtask

  task automatic seq(input string nm, input logic [31:0] epc,
                     input logic [31:0] ebad);
    cyc(nm, 0, 0, 0, 0, 0, 32'h0, 32'h0, epc, 0, 0, ebad);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_total++;
        if (bus.pc === e.pc && bus.pc_plus4 === e.pc + 32'd4 &&
            bus.redirect === e.rd && bus.trap === e.tr &&
            bus.bad_target === e.bad) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got pc=%h p4=%h rd=%b tr=%b bad=%h want pc=%h p4=%h rd=%b tr=%b bad=%h",
                   e.name, bus.pc, bus.pc_plus4, bus.redirect,
                   bus.trap, bus.bad_target, e.pc, e.pc + 32'd4,
                   e.rd, e.tr, e.bad);
        end
      end
    end
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    push("reset", 32'h0, 0, 0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 1; i <= 8; i++)
      seq("seq_start", 32'(i * 4), 32'h0);

    cyc("br_taken", 0, 1, 1, 0, 0, 32'hFFFF_FFF0, 32'h0,
        32'h10, 1, 0, 32'h0);
    for (int i = 0; i < 4; i++)
      seq("seq_back", 32'h14 + 32'(i * 4), 32'h0);
    cyc("br_not_taken", 0, 1, 0, 0, 0, 32'hFFFF_FFF0, 32'h0,
        32'h24, 0, 0, 32'h0);
    cyc("taken_no_br", 0, 0, 1, 0, 0, 32'hFFFF_FFF0, 32'h0,
        32'h28, 0, 0, 32'h0);
    for (int i = 0; i < 6; i++)
      seq("seq_to_40", 32'h2C + 32'(i * 4), 32'h0);

    cyc("jalr_over_jal_misal", 0, 0, 0, 1, 1, 32'h0, 32'h1003,
        32'h100, 1, 1, 32'h1002);
    cyc("trap_exit", 1, 1, 1, 1, 0, 32'h40, 32'h0,
        32'h104, 0, 0, 32'h1002);

    cyc("jalr_to_8", 0, 0, 0, 0, 1, 32'h0, 32'h8,
        32'h8, 1, 0, 32'h1002);
    for (int i = 0; i < 3; i++)
      cyc("stall_hold", 1, 0, 0, 1, 0, 32'h80, 32'h0,
          32'h8, 0, 0, 32'h1002);
    cyc("jal_after_stall", 0, 0, 0, 1, 0, 32'h80, 32'h0,
        32'h88, 1, 0, 32'h1002);

    cyc("jal_bit0_misal", 0, 0, 0, 1, 0, 32'h1, 32'h0,
        32'h100, 1, 1, 32'h89);
    seq("trap_exit2", 32'h104, 32'h89);

    cyc("jalr_to_top", 0, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC,
        32'hFFFF_FFFC, 1, 0, 32'h89);
    seq("pc_wrap", 32'h0, 32'h89);
    cyc("jalr_wrap_clr0", 0, 0, 0, 0, 1, 32'h15, 32'hFFFF_FFF0,
        32'h4, 1, 0, 32'h89);
    cyc("jalr_clr0", 0, 0, 0, 0, 1, 32'h0, 32'h201,
        32'h200, 1, 0, 32'h89);
    cyc("br_bit1_misal", 0, 1, 1, 0, 0, 32'h6, 32'h0,
        32'h100, 1, 1, 32'h206);
    seq("trap_exit3", 32'h104, 32'h206);

    cyc("jalr_misal2", 0, 0, 0, 0, 1, 32'h0, 32'h2,
        32'h100, 1, 1, 32'h2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_reset_in_trap", 32'h0, 0, 0, 32'h0);
    -> sample_ev;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seq("after_reset", 32'h4, 32'h0);

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter of the single-cycle core.
- Downstream consumer of the branch comparator's branch_taken result; selects the next PC from sequential, branch, JAL and JALR targets.
- Registers the PC and handles stall.
- Detects misaligned control-transfer targets and sequences a one-cycle trap entry to a fixed vector.

Parameters:
- WIDTH, 32, PC/address/immediate width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on misaligned-target trap.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  freeze PC and FSM this cycle.
- is_branch  input  1  current instruction is a conditional branch.
- branch_taken  input  1  comparator result; ignored unless is_branch.
- is_jal  input  1  current instruction is JAL.
- is_jalr  input  1  current instruction is JALR.
- imm  input  WIDTH  sign-extended immediate (B/J/I form, already decoded).
- rs1_val  input  WIDTH  rs1 operand for JALR.
- pc  output  WIDTH  current PC (registered).
- pc_plus4  output  WIDTH  pc + 4, combinational; this is the link value for JAL/JALR.
- redirect  output  1  registered pulse: last update was a non-sequential PC load.
- trap  output  1  high for exactly the one TRAP-state cycle.
- bad_target  output  WIDTH  registered misaligned target that caused the last trap.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, state=RUN.
  - redirect=0, trap=0, bad_target=0.
- Target computation:
  - branch/JAL target = pc + imm.
  - JALR target = (rs1_val + imm) with bit0 cleared.
  - All additions are modulo 2^WIDTH (wrap silently).
- Selection priority, highest first:
  - is_jalr.
  - is_jal.
  - is_branch & branch_taken.
  - Otherwise sequential: pc_plus4.
  - branch_taken with is_branch=0 has no effect.
- Misaligned check: a selected non-sequential target with bit[1]=1 is misaligned. Bit0 can only be set on branch/JAL targets; that case is also misaligned.
- FSM states RUN and TRAP:
  - RUN, stall=1: pc, state and bad_target hold; redirect driven 0.
  - RUN, aligned target selected: pc <= target next edge; redirect=1 for the following cycle.
  - RUN, sequential: pc <= pc+4; redirect=0.
  - RUN, misaligned target: pc <= TRAP_VEC; bad_target <= target; state <= TRAP; redirect=1.
  - TRAP: trap=1 for one cycle. Instruction inputs are ignored and stall is ignored. pc holds TRAP_VEC. Next state is RUN with trap=0, and fetch proceeds from TRAP_VEC.
- Timing: all outputs except pc_plus4 are registered; latency is 1 cycle from input decision to pc update.
- Reset mid-TRAP returns to RUN at RESET_PC; bad_target clears.
- Wrap-around: pc=32'hFFFF_FFFC sequential gives 32'h0000_0000 with no trap.

Optional Feature:
- Macro: BRANCH_PERF_CNT_EN.
- When defined, adds two output ports, each WIDTH wide, saturating at all-ones, reset to 0:
  - br_count: increments on each non-stalled RUN cycle with is_branch=1.
  - br_taken_count: increments when is_branch & branch_taken in such a cycle.
  - Misaligned branches still count.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset release with RESET_PC=0 and no control inputs -> pc sequence 0, 4, 8, 12; redirect=0; trap=0.
- pc=0x20, is_branch=1, branch_taken=1, imm=0xFFFFFFF0 -> next pc=0x10, redirect=1 one cycle; the same stimulus with branch_taken=0 -> pc=0x24.
- pc=0x40, is_jalr=1 and is_jal=1 simultaneously, rs1_val=0x1003, imm=0 -> pc=0x1002 is misaligned; next cycle pc=0x100, trap=1, bad_target=0x1002; following cycle trap=0 and pc=0x104.
- stall=1 for 3 cycles with is_jal=1, imm=0x80 at pc=0x8 -> pc holds 0x8; on the first stall=0 cycle pc -> 0x88.
- pc=0xFFFFFFFC sequential -> pc=0x0, no trap.
- Assert rst_n low during the TRAP cycle -> pc=RESET_PC immediately (asynchronously); trap=0; bad_target=0.
